mul_accumulator: RTL and testbench

- Downstream stage of booth_multiplier.
- Consumes the 64-bit product stream over valid/ready and accumulates a group of len products into a wide accumulator.
- Presents the group sum (dot-product style) on its own valid/ready output.
- Its valid_i/ready_o pair connects to the multiplier's valid_o/ready_i.

---
 rtl/mul_pkg.sv | 28 ++
 rtl/mul_acc_add.sv | 42 ++++
 rtl/mul_accumulator.sv | 105 ++++++++++
 tb/tb_mul_accumulator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the product accumulator (mul_accumulator, mul_acc_add).
// Optional build macro MUL_ACC_SAT_EN selects saturating accumulation in mul_acc_add.
package mul_pkg;

    localparam int unsigned RES_W_DEF = 64;
    localparam int unsigned ACC_W_DEF = 72;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned EXT_MAX   = 256;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Widen the low w bits of v, replicating bit w-1 when sgn is set.
    function automatic logic [EXT_MAX-1:0] ext_val(
        input logic [EXT_MAX-1:0] v,
        input int unsigned        w,
        input logic               sgn
    );
        logic [EXT_MAX-1:0] mask;
        logic               fill;
        mask = (EXT_MAX'(1) << w) - EXT_MAX'(1);
        fill = sgn && (((v >> (w - 1)) & EXT_MAX'(1)) != '0);
        return fill ? (v | ~mask) : (v & mask);
    endfunction

endpackage

// File: rtl/mul_acc_add.sv
// Combinational ACC_W accumulator adder with signed/unsigned overflow detect.
// With MUL_ACC_SAT_EN defined the sum clamps on overflow instead of wrapping.
module mul_acc_add
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    input  logic             i_sgn,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W:0]   w_full;
    logic [ACC_W-1:0] w_raw;
    logic             w_carry;
    logic             w_sovf;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign w_raw   = w_full[ACC_W-1:0];
    assign w_carry = w_full[ACC_W];
    assign w_sovf  = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
    assign o_ovf   = i_sgn ? w_sovf : w_carry;

`ifdef MUL_ACC_SAT_EN
    always_comb begin
        o_sum = w_raw;
        if (o_ovf) begin
            if (i_sgn) begin
                // Signed overflow direction follows the shared operand sign.
                o_sum = i_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                o_sum = '1;
            end
        end
    end
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates groups of len_i products from booth_multiplier and presents each group sum.
// Build macro MUL_ACC_SAT_EN (see mul_acc_add) enables saturating accumulation.
module mul_accumulator
    import mul_pkg::*;
#(
    parameter int unsigned RES_W = RES_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [RES_W-1:0] prod_i,
    input  logic             signal_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_sgn;
    logic             r_ovf;

    logic             w_beat;
    logic             w_out_hs;
    logic             w_first;
    logic             w_sgn;
    logic [CNT_W-1:0] w_len_in;
    logic [CNT_W-1:0] w_len;
    logic             w_last;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;

    // First beat of a group uses the live len/sign; later beats use the captured copies.
    assign w_first  = (r_cnt == '0);
    assign w_sgn    = w_first ? signal_i : r_sgn;
    assign w_len_in = (len_i == '0) ? CNT_W'(1) : len_i;
    assign w_len    = w_first ? w_len_in : r_len;
    assign w_last   = (r_cnt == w_len - CNT_W'(1));
    assign w_beat   = valid_i && ready_o;
    assign w_out_hs = valid_o && ready_i;
    assign w_ext    = ACC_W'(ext_val(EXT_MAX'(prod_i), RES_W, w_sgn));

    mul_acc_add #(.ACC_W(ACC_W)) u_add (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .i_sgn (w_sgn),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_beat && w_last) w_next = HOLD;
            HOLD:    if (w_out_hs)         w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    always_comb begin
        ready_o = (r_state == ACCUM) && !rst;
        valid_o = (r_state == HOLD);
        acc_o   = r_acc;
        ovf_o   = r_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_sgn <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_add_ovf;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_first) begin
                r_len <= w_len_in;
                r_sgn <= signal_i;
            end
        end else if (w_out_hs) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Scoreboard bench for mul_accumulator: default 72-bit instance plus a 64-bit instance for overflow.
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] prod_i = '0;
    logic        signal_i = 1'b0;
    logic [7:0]  len_i = 8'd1;
    logic        ready_i = 1'b1;

    logic        va = 1'b0, vb = 1'b0;
    logic        rdy_a, rdy_b, vo_a, vo_b, ovf_a, ovf_b;
    logic [71:0] acc_a;
    logic [63:0] acc_b;

    int total = 0;
    int bad   = 0;

    logic [72:0] qa[$];
    logic [72:0] qb[$];

    always #5 clk = ~clk;

    mul_accumulator u_dut_a (
        .clk(clk), .rst(rst), .valid_i(va), .ready_o(rdy_a), .prod_i(prod_i),
        .signal_i(signal_i), .len_i(len_i), .valid_o(vo_a), .ready_i(ready_i),
        .acc_o(acc_a), .ovf_o(ovf_a)
    );

    mul_accumulator #(.RES_W(64), .ACC_W(64), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .valid_i(vb), .ready_o(rdy_b), .prod_i(prod_i),
        .signal_i(signal_i), .len_i(len_i), .valid_o(vo_b), .ready_i(ready_i),
        .acc_o(acc_b), .ovf_o(ovf_b)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit sel, input logic ovf, input logic [71:0] acc);
        if (sel) qb.push_back({ovf, acc});
        else     qa.push_back({ovf, acc});
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic beat(input bit sel, input logic [63:0] p, input logic s, input logic [7:0] l);
        logic ok;
        prod_i = p; signal_i = s; len_i = l;
        if (sel) vb = 1'b1; else va = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = sel ? rdy_b : rdy_a;
            @(posedge clk);
            #1;
        end
        va = 1'b0; vb = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL beat_timeout: got no ready want ready (sel=%0d)", sel);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        logic [72:0] e;
        if (!rst) begin
            if (vo_a && ready_i) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_a: got sum %0h want none", acc_a);
                end else begin
                    e = qa.pop_front();
                    chk("sum_a", acc_a, e[71:0]);
                    chk("ovf_a", 72'(ovf_a), 72'(e[72]));
                end
            end
            if (vo_b && ready_i) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_b: got sum %0h want none", acc_b);
                end else begin
                    e = qb.pop_front();
                    chk("sum_b", 72'(acc_b), e[71:0]);
                    chk("ovf_b", 72'(ovf_b), 72'(e[72]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_valid", 72'(vo_a), 72'(0));
        chk("rst_ready", 72'(rdy_a), 72'(0));
        chk("rst_acc", acc_a, 72'(0));
        chk("rst_ovf", 72'(ovf_a), 72'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1);

        // Reset mid-group: two of four beats, then reset, then a fresh len=1 group.
        beat(0, 64'd100, 1'b0, 8'd4);
        beat(0, 64'd200, 1'b0, 8'd4);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 72'(vo_a), 72'(0));
        chk("midrst_ready", 72'(rdy_a), 72'(0));
        chk("midrst_acc", acc_a, 72'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, 1'b0, 72'd7);
        beat(0, 64'd7, 1'b0, 8'd1);
        cyc(1);

        // Unsigned group of three with latency check.
        push(0, 1'b0, 72'h01_0000_0000_0000_000E);
        beat(0, 64'd5, 1'b0, 8'd3);
        beat(0, 64'd10, 1'b0, 8'd3);
        chk("uns_not_early", 72'(vo_a), 72'(0));
        beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'd3);
        chk("uns_latency", 72'(vo_a), 72'(1));
        cyc(1);

        // Signed group: -3 + 10.
        push(0, 1'b0, 72'd7);
        beat(0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 8'd2);
        beat(0, 64'd10, 1'b1, 8'd2);
        cyc(1);

        // Backpressure in HOLD with valid_i asserted.
        ready_i = 1'b0;
        push(0, 1'b0, 72'h55);
        push(0, 1'b0, 72'hDEAD);
        beat(0, 64'h55, 1'b0, 8'd1);
        prod_i = 64'hDEAD; signal_i = 1'b0; len_i = 8'd1; va = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 72'(rdy_a), 72'(0));
            chk("bp_acc", acc_a, 72'h55);
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_back", 72'(rdy_a), 72'(1));
        @(posedge clk); #1;
        va = 1'b0;
        chk("bp_next_accepted", 72'(vo_a), 72'(1));
        cyc(1);

        // len_i = 0 behaves as 1.
        push(0, 1'b0, 72'd9);
        beat(0, 64'd9, 1'b0, 8'd0);
        chk("len0_done", 72'(vo_a), 72'(1));
        cyc(1);

        // len_i changed mid-group has no effect.
        push(0, 1'b0, 72'd3);
        beat(0, 64'd1, 1'b0, 8'd2);
        beat(0, 64'd2, 1'b0, 8'd5);
        chk("lenchg_done", 72'(vo_a), 72'(1));
        cyc(1);

        // 64-bit instance: signed and unsigned overflow, then a clean group.
`ifdef MUL_ACC_SAT_EN
        push(1, 1'b1, 72'h7FFF_FFFF_FFFF_FFFF);
        push(1, 1'b1, 72'hFFFF_FFFF_FFFF_FFFF);
`else
        push(1, 1'b1, 72'h8000_0000_0000_0000);
        push(1, 1'b1, 72'h1);
`endif
        push(1, 1'b0, 72'h4);
        beat(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 8'd2);
        beat(1, 64'd1, 1'b1, 8'd2);
        cyc(1);
        beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'd2);
        beat(1, 64'd2, 1'b0, 8'd2);
        cyc(1);
        beat(1, 64'd4, 1'b1, 8'd1);
        cyc(5);

        chk("qa_drained", 72'(qa.size()), 72'(0));
        chk("qb_drained", 72'(qb.size()), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
